accum_rmw_double_buffer: RTL
============================

// Module: accum_rmw_double_buffer
// PURPOSE
//  Two-bank ping-pong accumulation buffer between the systolic array and the output drain.
//  Array side does per-lane read-modify-write accumulation into the active bank; drain side
//  serialises the idle bank one OC lane per beat over a valid/ready handshake and can zero it.
//  Bank swap is a request that is accepted only when the drain is idle.
// PARAMETERS
//  OC_WIDTH       16  bits per output-channel lane
//  NUM_OC         4   lanes per word; DATA_WIDTH = OC_WIDTH*NUM_OC (localparam)
//  DEPTH          32  words per bank
//  ADDR_WIDTH     5   word address width, $clog2(DEPTH)
//  CLEAR_ON_DRAIN 1   1: drain writes zero to each word after its last lane is accepted
// PORTS
//  clk          in   1             clock, all logic on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  switch_banks in   1             swap request, single-cycle pulse
//  switch_ready out  1             high when a swap request would be accepted (= ~drain_busy)
//  acc_bank     out  1             bank currently receiving accumulations
//  acc_valid    in   1             accumulate request (always accepted, no backpressure)
//  acc_first    in   1             1: overwrite word with acc_data instead of adding
//  acc_adr      in   ADDR_WIDTH    word address in the active bank
//  acc_data     in   DATA_WIDTH    NUM_OC packed partial sums, lane 0 = [OC_WIDTH-1:0]
//  drain_start  in   1             start draining the idle bank, pulse
//  drain_len    in   ADDR_WIDTH+1  words to drain, from address 0 upward (0..DEPTH)
//  drain_busy   out  1             drain in progress
//  drain_done   out  1             one-cycle pulse after the last beat (or the zero-length start)
//  out_valid    out  1             out_data valid
//  out_ready    in   1             consumer accepts beat when out_valid & out_ready
//  out_data     out  OC_WIDTH      one lane of the drained word
// BEHAVIOUR
//  Reset: acc_bank=0, drain_busy=0, drain_done=0, out_valid=0, out_data=0, switch_ready=1,
//   RMW stage and FSM cleared; RAM contents are not cleared (undefined after power-up).
//  Each bank is an independent 1R1W sync RAM with 1-cycle read latency.
//  RMW pipeline: request accepted at edge t issues a RAM read and loads stage S1 {adr,data,
//   first,bank}. In cycle t+1: sum = first ? data : rdata+data, per lane, mod 2^OC_WIDTH
//   (no carry between lanes, no saturation). Write commits at edge t+2.
//  Hazard: a request at t+1 to the same adr/bank as S1 takes S1's sum as its read operand
//   (bypass), so back-to-back same-address accumulations are exact. One request per cycle.
//  Swap: accepted at the edge when switch_banks & ~drain_busy; acc_bank toggles. An acc
//   request in the same cycle goes to the old bank; an in-flight S1 write finishes into the
//   bank recorded in S1. A swap with drain_busy=1 is dropped (no queueing).
//  Drain FSM on bank ~acc_bank: IDLE -> READ (issue read of word w) -> LOAD (capture word)
//   -> EMIT (lane k=0..NUM_OC-1, out_valid held until out_ready; out_data stable while
//   stalled) -> [CLEAR: write 0 to w if CLEAR_ON_DRAIN] -> READ w+1, or DONE after w=len-1.
//   DONE pulses drain_done for one cycle, returns to IDLE.
//  drain_start ignored while busy. drain_len=0: no beats, drain_done pulses the cycle after
//   start, drain_busy stays 0. drain_len>DEPTH is clamped to DEPTH.
//  drain_busy rises the cycle after drain_start and falls with drain_done.
// TESTING
//  1 Reset mid-drain (beat 3 of 8) -> next cycle out_valid=0, drain_busy=0, acc_bank=0.
//  2 acc_first adr 5 data {1,2,3,4}, then adr 5 data {1,1,1,1} back-to-back, swap, drain len 6
//    -> beats 20..23 are {2,3,4,5}.
//  3 Lane wrap: lane0 0xFFFF + 0x0002 -> lane0 0x0001, lane1 unaffected by carry.
//  4 Drain len 2 with out_ready toggling 1,0,0,1 -> exactly 2*NUM_OC beats, out_data stable
//    during stalls, drain_done one pulse; with CLEAR_ON_DRAIN re-drain returns zeros.
//  5 switch_banks while drain_busy -> acc_bank unchanged; after drain_done swap is accepted.
//  6 Swap and acc_valid same cycle at adr 3 -> word lands in old bank, visible in next drain.

Source files
------------

// File: rtl/accum_rmw_double_buffer.sv
// Ping-pong accumulation buffer: per-lane read-modify-write into the active bank,
// lane-serial drain (with optional zeroing) of the idle bank.
module accum_rmw_double_buffer #(
    parameter int OC_WIDTH       = 16,
    parameter int NUM_OC         = 4,
    parameter int DEPTH          = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_DRAIN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         switch_banks,
    output logic                         switch_ready,
    output logic                         acc_bank,
    input  logic                         acc_valid,
    input  logic                         acc_first,
    input  logic [ADDR_WIDTH-1:0]        acc_adr,
    input  logic [OC_WIDTH*NUM_OC-1:0]   acc_data,
    input  logic                         drain_start,
    input  logic [ADDR_WIDTH:0]          drain_len,
    output logic                         drain_busy,
    output logic                         drain_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OC_WIDTH-1:0]          out_data
);

    localparam int DATA_WIDTH = OC_WIDTH * NUM_OC;
    localparam int LANE_W     = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_EMIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t state, nstate;

    logic                  bank_q;
    logic                  swap_ok;
    logic                  dbank;

    logic                  s1_valid;
    logic                  s1_first;
    logic                  s1_bank;
    logic                  s1_byp;
    logic [ADDR_WIDTH-1:0] s1_adr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [DATA_WIDTH-1:0] s1_byp_data;
    logic [DATA_WIDTH-1:0] s1_op;
    logic [DATA_WIDTH-1:0] s1_sum;
    logic                  byp_hit;

    logic [ADDR_WIDTH-1:0] w_q;
    logic [LANE_W-1:0]     k_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   len_in;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  last_lane;
    logic                  last_word;

    logic [1:0]                      we;
    logic [1:0]                      re;
    logic [1:0][ADDR_WIDTH-1:0]      wadr;
    logic [1:0][ADDR_WIDTH-1:0]      radr;
    logic [1:0][DATA_WIDTH-1:0]      wdata;
    logic [1:0][DATA_WIDTH-1:0]      rdata;

    assign drain_busy   = (state == S_READ) || (state == S_LOAD) ||
                          (state == S_EMIT) || (state == S_CLEAR);
    assign drain_done   = (state == S_DONE);
    assign out_valid    = (state == S_EMIT);
    assign switch_ready = ~drain_busy;
    assign swap_ok      = switch_banks & ~drain_busy;
    assign acc_bank     = bank_q;
    assign dbank        = ~bank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_q <= 1'b0;
        else        bank_q <= bank_q ^ swap_ok;
    end

    // A request to the word S1 is still writing reads S1's sum, not the stale RAM word.
    assign byp_hit = acc_valid & s1_valid & (s1_adr == acc_adr) & (s1_bank == bank_q);

    always_comb begin
        s1_sum = '0;
        s1_op  = s1_byp ? s1_byp_data : rdata[s1_bank];
        for (int i = 0; i < NUM_OC; i++) begin
            s1_sum[i*OC_WIDTH +: OC_WIDTH] = s1_first ?
                s1_data[i*OC_WIDTH +: OC_WIDTH] :
                s1_op[i*OC_WIDTH +: OC_WIDTH] + s1_data[i*OC_WIDTH +: OC_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_bank     <= 1'b0;
            s1_byp      <= 1'b0;
            s1_adr      <= '0;
            s1_data     <= '0;
            s1_byp_data <= '0;
        end else begin
            s1_valid <= acc_valid;
            if (acc_valid) begin
                s1_first    <= acc_first;
                s1_bank     <= bank_q;
                s1_adr      <= acc_adr;
                s1_data     <= acc_data;
                s1_byp      <= byp_hit;
                s1_byp_data <= s1_sum;
            end
        end
    end

    assign len_in    = (drain_len > DEPTH_L) ? DEPTH_L : drain_len;
    assign last_lane = (k_q == LANE_W'(NUM_OC - 1));
    assign last_word = ({1'b0, w_q} + LEN_ONE == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:  if (drain_start)
                         nstate = (drain_len == '0) ? S_DONE : S_READ;
            S_READ:  nstate = S_LOAD;
            S_LOAD:  nstate = S_EMIT;
            S_EMIT:  if (out_ready && last_lane) begin
                         if (CLEAR_ON_DRAIN) nstate = S_CLEAR;
                         else if (last_word) nstate = S_DONE;
                         else                nstate = S_READ;
                     end
            S_CLEAR: nstate = last_word ? S_DONE : S_READ;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q    <= '0;
            k_q    <= '0;
            len_q  <= '0;
            word_q <= '0;
        end else begin
            if (state == S_IDLE && drain_start) begin
                len_q <= len_in;
                w_q   <= '0;
                k_q   <= '0;
            end
            if (state == S_LOAD) begin
                word_q <= rdata[dbank];
                k_q    <= '0;
            end
            if (state == S_EMIT && out_ready && !last_lane)
                k_q <= k_q + LANE_W'(1);
            if ((state == S_EMIT || state == S_CLEAR) && nstate == S_READ)
                w_q <= w_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            if (k_q == LANE_W'(i)) out_data = word_q[i*OC_WIDTH +: OC_WIDTH];
        end
    end

    // Array side and drain side always address opposite banks, so each bank
    // sees at most one reader; the write port favours the in-flight S1 commit.
    always_comb begin
        we    = '0;
        re    = '0;
        wadr  = '0;
        radr  = '0;
        wdata = '0;
        for (int b = 0; b < 2; b++) begin
            if (s1_valid && s1_bank == b[0]) begin
                we[b]    = 1'b1;
                wadr[b]  = s1_adr;
                wdata[b] = s1_sum;
            end else if (CLEAR_ON_DRAIN && state == S_CLEAR && dbank == b[0]) begin
                we[b]    = 1'b1;
                wadr[b]  = w_q;
            end
            if (acc_valid && bank_q == b[0]) begin
                re[b]   = 1'b1;
                radr[b] = acc_adr;
            end else if (state == S_READ && dbank == b[0]) begin
                re[b]   = 1'b1;
                radr[b] = w_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        // Write-first so a drain read racing a late S1 commit after a swap sees new data.
        always_ff @(posedge clk) begin
            if (we[b]) mem[wadr[b]] <= wdata[b];
            if (re[b])
                rd_q <= (we[b] && wadr[b] == radr[b]) ? wdata[b] : mem[radr[b]];
        end

        assign rdata[b] = rd_q;
    end

endmodule
